// File: rtl/fsm_pkg.sv
// fsm_pkg: shared event-code width, idle code and conditioner defaults
package fsm_pkg;
  localparam int E_W = 3;
  localparam logic [E_W-1:0] E_IDLE = '0;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
endpackage

// File: rtl/fsm_input_conditioner_if.sv
// fsm_input_conditioner_if: raw inputs, hold and conditioned event code
interface fsm_input_conditioner_if import fsm_pkg::*; ();
  logic [E_W-1:0] btn_in;
  logic hold;
  logic [E_W-1:0] E;
  logic e_changed;
  modport master (output btn_in, hold, input E, e_changed);
  modport slave (input btn_in, hold, output E, e_changed);
endinterface

// File: rtl/fsm_debounce_ch.sv
// fsm_debounce_ch: one-bit synchroniser, debounce counter and stable flag
module fsm_debounce_ch import fsm_pkg::*; #(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic clk,
  input logic reset,
  input logic btn_in,
  output logic stable,
  output logic cnt_zero
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] sr;
  logic [CW-1:0] cnt;
  logic sync;
  assign sync = sr[SYNC_STAGES-1];
  assign cnt_zero = cnt == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sr <= '0;
      cnt <= '0;
      stable <= 1'b0;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], btn_in};
      if (sync == stable) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        stable <= sync;
      end else cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/fsm_input_conditioner.sv
// fsm_input_conditioner: debounces three raw inputs into a coherent event code
// that only moves when every channel is quiet, plus a one-cycle change strobe
module fsm_input_conditioner import fsm_pkg::*; #(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic clk,
  input logic reset,
  fsm_input_conditioner_if.slave bus
);
  logic [E_W-1:0] stable, cnt_zero, e_q;
  logic e_chg, upd;
  for (genvar g = 0; g < E_W; g++) begin : g_ch
    fsm_debounce_ch #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk(clk),
      .reset(reset),
      .btn_in(bus.btn_in[g]),
      .stable(stable[g]),
      .cnt_zero(cnt_zero[g])
    );
  end
  // any channel mid-qualification blocks E so multi-bit moves land together
  assign upd = &cnt_zero && !bus.hold;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      e_q <= E_IDLE;
      e_chg <= 1'b0;
    end else begin
      e_chg <= upd && stable != e_q;
      if (upd) e_q <= stable;
    end
  assign bus.E = e_q;
  assign bus.e_changed = e_chg;
endmodule

// File: tb/tb_fsm_input_conditioner.sv
// tb_fsm_input_conditioner: directed scenarios plus randomized run against a behavioural model
module tb_fsm_input_conditioner;
  localparam int SS = 2;
  localparam int DC = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errs = 0;
  int checks = 0;
  fsm_input_conditioner_if bus();
  fsm_input_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;

  // model: delayed view of the inputs, run lengths of disagreement, accepted levels
  bit [2:0] hist[SS];
  int run[3];
  bit [2:0] stab, me;
  bit mch;
  always @(posedge clk or posedge reset) begin
    bit [2:0] sv;
    bit q;
    if (reset) begin
      for (int k = 0; k < SS; k++) hist[k] = '0;
      for (int k = 0; k < 3; k++) run[k] = 0;
      stab = '0;
      me = '0;
      mch = 1'b0;
    end else begin
      q = (run[0] == 0) && (run[1] == 0) && (run[2] == 0);
      sv = hist[SS-1];
      for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = bus.btn_in;
      if (q && !bus.hold) begin
        mch = stab != me;
        me = stab;
      end else mch = 1'b0;
      for (int k = 0; k < 3; k++)
        if (sv[k] == stab[k]) run[k] = 0;
        else if (run[k] + 1 == DC) begin
          stab[k] = sv[k];
          run[k] = 0;
        end else run[k]++;
    end
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_E", {1'b0, bus.E}, {1'b0, me});
    chk("model_chg", {3'b0, bus.e_changed}, {3'b0, mch});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [2:0] e, input logic c);
    chk({nm, "_E"}, {1'b0, bus.E}, {1'b0, e});
    chk({nm, "_chg"}, {3'b0, bus.e_changed}, {3'b0, c});
  endtask

  initial begin
    bus.btn_in = '0;
    bus.hold = 1'b0;
    step(3);
    reset = 1'b0;
    bus.btn_in = 3'b011;
    step(12);
    // 1: reset asserted mid-cycle clears outputs immediately
    #2 reset = 1'b1;
    #1 lit("reset_imm", 3'b000, 1'b0);
    bus.btn_in = '0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      lit("reset_hold", 3'b000, 1'b0);
    end
    reset = 1'b0;
    step(2);
    // 2: isolated change appears on the 7th edge
    bus.btn_in = 3'b001;
    step(6);
    lit("lat_pre", 3'b000, 1'b0);
    step(1);
    lit("lat_at", 3'b001, 1'b1);
    step(1);
    lit("lat_post", 3'b001, 1'b0);
    bus.btn_in = '0;
    step(10);
    lit("lat_back", 3'b000, 1'b0);
    // 3: 3-cycle bounces never qualify
    for (int r = 0; r < 5; r++) begin
      bus.btn_in = 3'b001;
      for (int k = 0; k < 3; k++) begin step(1); lit("bounce", 3'b000, 1'b0); end
      bus.btn_in = 3'b000;
      for (int k = 0; k < 3; k++) begin step(1); lit("bounce", 3'b000, 1'b0); end
    end
    step(10);
    lit("bounce_end", 3'b000, 1'b0);
    // 4: bits two cycles apart arrive together
    bus.btn_in = 3'b001;
    step(2);
    lit("coh", 3'b000, 1'b0);
    bus.btn_in = 3'b101;
    for (int k = 3; k <= 8; k++) begin step(1); lit("coh", 3'b000, 1'b0); end
    step(1);
    lit("coh_at", 3'b101, 1'b1);
    step(1);
    lit("coh_post", 3'b101, 1'b0);
    bus.btn_in = '0;
    step(12);
    lit("coh_back", 3'b000, 1'b0);
    // 5: hold freezes E while debouncing continues
    bus.hold = 1'b1;
    bus.btn_in = 3'b010;
    for (int k = 0; k < 20; k++) begin step(1); lit("hold", 3'b000, 1'b0); end
    bus.hold = 1'b0;
    step(1);
    lit("hold_rel", 3'b010, 1'b1);
    step(1);
    lit("hold_post", 3'b010, 1'b0);
    bus.btn_in = '0;
    step(12);
    // 6: reset mid-debounce forces full requalification
    bus.btn_in = 3'b100;
    step(3);
    reset = 1'b1;
    #1 lit("rst_mid", 3'b000, 1'b0);
    #2 reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin step(1); lit("rst_requal", 3'b000, 1'b0); end
    step(1);
    lit("rst_requal_at", 3'b100, 1'b1);
    bus.btn_in = '0;
    step(12);
    // randomized run: mostly slow changes with bursts of bounce, hold and rare resets
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8) bus.btn_in = bus.btn_in ^ (3'd1 << $urandom_range(0, 2));
      else if (r < 10) bus.btn_in = 3'($urandom);
      if ($urandom_range(0, 99) < 3) bus.hold = ~bus.hold;
      if ($urandom_range(0, 999) < 3) begin
        reset = 1'b1;
        step($urandom_range(1, 3));
        reset = 1'b0;
      end
      step(1);
    end
    bus.hold = 1'b0;
    step(20);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
